// File: rtl/scene_renderer_if.sv
// Signal bundle between the VGA timing generator / GamePhysics side and the
// scene renderer.
//   master : drives pixel coordinates, ball/paddle state, BALL_LOST and the
//            block-state read data; observes the renderer outputs.
//   slave  : the renderer; drives BLOCK_ADDR, START_UPDATE, RGB, RGB_VALID.
interface scene_renderer_if;
  logic [9:0] PIXEL_X;
  logic [9:0] PIXEL_Y;
  logic       PIXEL_VISIBLE;
  logic [9:0] PADDLE_X_PIXEL;
  logic [9:0] BALL_X_PIXEL;
  logic [9:0] BALL_Y_PIXEL;
  logic       BALL_LOST;
  logic [6:0] BLOCK_ADDR;
  logic       BLOCK_ALIVE;
  logic       START_UPDATE;
  logic [7:0] RGB;
  logic       RGB_VALID;

  modport master (
    output PIXEL_X, PIXEL_Y, PIXEL_VISIBLE, PADDLE_X_PIXEL, BALL_X_PIXEL,
           BALL_Y_PIXEL, BALL_LOST, BLOCK_ALIVE,
    input  BLOCK_ADDR, START_UPDATE, RGB, RGB_VALID
  );

  modport slave (
    input  PIXEL_X, PIXEL_Y, PIXEL_VISIBLE, PADDLE_X_PIXEL, BALL_X_PIXEL,
           BALL_Y_PIXEL, BALL_LOST, BLOCK_ALIVE,
    output BLOCK_ADDR, START_UPDATE, RGB, RGB_VALID
  );
endinterface

// File: rtl/scene_renderer.sv
// scene_renderer: per-pixel colour generator between the VGA timing generator
// and the DAC pins.
//   CLK, RESET : system clock, synchronous active-high reset
//   bus.slave  : pixel stream in, ball/paddle/BALL_LOST from GamePhysics,
//                block-state read port (BLOCK_ADDR out, BLOCK_ALIVE in one
//                cycle later), START_UPDATE pulse out, registered RGB and
//                RGB_VALID out (three edges after the pixel is sampled).
// The horizontal visible extent is taken entirely from PIXEL_VISIBLE, so no
// line-width parameter is needed here.
module scene_renderer #(
  parameter int V_ACTIVE   = 480,
  parameter int BLOCK_X0   = 32,
  parameter int BLOCK_Y0   = 64,
  parameter int BLOCK_COLS = 9,
  parameter int BLOCK_ROWS = 8,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_LEN = 64,
  parameter int PADDLE_Y   = 448,
  parameter int WALL_L_X   = 16,
  parameter int WALL_R_X   = 616,
  parameter int CEIL_Y     = 48
) (
  input logic             CLK,
  input logic             RESET,
  scene_renderer_if.slave bus
);

  // Address one past the last block; the block RAM always reads it as dead.
  localparam logic [6:0] DUMMY_ADDR = 7'(BLOCK_COLS * BLOCK_ROWS);
  localparam logic [9:0] GRID_W     = 10'(64 * BLOCK_COLS);
  localparam logic [9:0] GRID_H     = 10'(16 * BLOCK_ROWS);

  typedef struct packed {
    logic       vis;
    logic       lost;
    logic       ball;
    logic       paddle;
    logic       block;   // in grid and not on a block border
    logic       wall;
    logic [2:0] row;
  } flags_t;

  function automatic logic [7:0] row_colour(input logic [2:0] row);
    case (row)
      3'd0:    return 8'hE0;
      3'd1:    return 8'hEC;
      3'd2:    return 8'hFC;
      3'd3:    return 8'h1C;
      3'd4:    return 8'h1F;
      3'd5:    return 8'h03;
      3'd6:    return 8'hE3;
      default: return 8'h92;
    endcase
  endfunction

  // Half-open span test on 11-bit values so lo+len never wraps.
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d, paddle_x_q, paddle_x_d;
  logic        vis_prev_q, vis_prev_d, start_q, start_d;
  logic [6:0]  block_addr_q, block_addr_d;
  flags_t      s1_q, s1_d, s2_q, s2_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        rgb_valid_q, rgb_valid_d;

  logic [9:0]  dx, dy;
  logic [10:0] x11, y11;
  logic        in_grid;

  // NOTE: every always_comb output gets a default at the top so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    paddle_x_d = paddle_x_q;

    // Snapshot during the blank line after the last visible line, so a whole
    // frame is drawn from one consistent set of positions.
    if (bus.PIXEL_Y == 10'(V_ACTIVE) && !bus.PIXEL_VISIBLE) begin
      ball_x_d   = bus.BALL_X_PIXEL;
      ball_y_d   = bus.BALL_Y_PIXEL;
      paddle_x_d = bus.PADDLE_X_PIXEL;
    end

    // Underflow wraps to a large value and falls out of range naturally.
    dx      = bus.PIXEL_X - 10'(BLOCK_X0);
    dy      = bus.PIXEL_Y - 10'(BLOCK_Y0);
    in_grid = (dx < GRID_W) && (dy < GRID_H);
    block_addr_d = in_grid ? 7'(dy[9:4]) * 7'(BLOCK_COLS) + 7'(dx[9:6])
                           : DUMMY_ADDR;

    x11 = {1'b0, bus.PIXEL_X};
    y11 = {1'b0, bus.PIXEL_Y};

    s1_d.vis    = bus.PIXEL_VISIBLE;
    s1_d.lost   = bus.BALL_LOST;
    s1_d.ball   = in_span(x11, {1'b0, ball_x_q}, 11'(BALL_SIZE)) &&
                  in_span(y11, {1'b0, ball_y_q}, 11'(BALL_SIZE));
    s1_d.paddle = in_span(x11, {1'b0, paddle_x_q}, 11'(PADDLE_LEN)) &&
                  in_span(y11, 11'(PADDLE_Y), 11'd8);
    s1_d.block  = in_grid && (dx[5:0] != 6'd0) && (dy[3:0] != 4'd0);
    // Side walls run from the ceiling down; the ceiling bridges both walls.
    s1_d.wall   = ((in_span(x11, 11'(WALL_L_X), 11'd8) ||
                    in_span(x11, 11'(WALL_R_X), 11'd8)) && (y11 >= 11'(CEIL_Y))) ||
                  (in_span(y11, 11'(CEIL_Y), 11'd8) &&
                   in_span(x11, 11'(WALL_L_X), 11'(WALL_R_X - WALL_L_X + 8)));
    s1_d.row    = dy[6:4];

    // Second stage only waits for the block RAM read data to arrive.
    s2_d = s1_q;

    rgb_d = 8'h00;
    if (s2_q.vis) begin
      if (s2_q.ball)                         rgb_d = 8'hFF;
      else if (s2_q.paddle)                  rgb_d = 8'h1F;
      else if (s2_q.block && bus.BLOCK_ALIVE) rgb_d = row_colour(s2_q.row);
      else if (s2_q.wall)                    rgb_d = 8'h92;
      else if (s2_q.lost)                    rgb_d = 8'h60;
    end
    rgb_valid_d = s2_q.vis;

    // Falling edge of PIXEL_VISIBLE on the last visible line.
    vis_prev_d = bus.PIXEL_VISIBLE;
    start_d    = vis_prev_q && !bus.PIXEL_VISIBLE &&
                 (bus.PIXEL_Y == 10'(V_ACTIVE - 1));
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      paddle_x_q   <= '0;
      vis_prev_q   <= 1'b0;
      start_q      <= 1'b0;
      block_addr_q <= DUMMY_ADDR;
      s1_q         <= '0;
      s2_q         <= '0;
      rgb_q        <= '0;
      rgb_valid_q  <= 1'b0;
    end else begin
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      paddle_x_q   <= paddle_x_d;
      vis_prev_q   <= vis_prev_d;
      start_q      <= start_d;
      block_addr_q <= block_addr_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      rgb_q        <= rgb_d;
      rgb_valid_q  <= rgb_valid_d;
    end
  end

  assign bus.BLOCK_ADDR   = block_addr_q;
  assign bus.START_UPDATE = start_q;
  assign bus.RGB          = rgb_q;
  assign bus.RGB_VALID    = rgb_valid_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Self-checking bench for scene_renderer: directed pixels with hand-computed
// colours go into a scoreboard; a negedge monitor pops and compares whenever
// RGB_VALID is high, and also checks BLOCK_ADDR and START_UPDATE timing.
module tb_scene_renderer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scene_renderer_if bus ();
  scene_renderer dut (.CLK(clk), .RESET(rst), .bus(bus));

  // Block-state RAM model: synchronous read, address 72 always dead.
  logic alive_mem [0:72];
  always @(posedge clk)
    bus.BLOCK_ALIVE <= (bus.BLOCK_ADDR <= 7'd72) ? alive_mem[bus.BLOCK_ADDR] : 1'b0;

  typedef struct { int issue; logic [7:0] rgb; string name; } exp_t;
  typedef struct { int issue; int addr; } addr_t;
  exp_t  sb [$];
  addr_t aq [$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int exp_start_cyc = -1;
  int n_start = 0, frames = 0;
  logic mon_en = 1'b0;
  logic start_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel for one cycle; visible pixels push their expected colour,
  // addr >= 0 also schedules a BLOCK_ADDR comparison one edge later.
  task automatic px(input int x, input int y, input logic vis,
                    input logic [7:0] rgb, input int addr, input string name);
    bus.PIXEL_X       = 10'(x);
    bus.PIXEL_Y       = 10'(y);
    bus.PIXEL_VISIBLE = vis;
    if (vis) sb.push_back('{cyc, rgb, name});
    if (addr >= 0) aq.push_back('{cyc, addr});
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(0, 0, 1'b0, 8'h00, -1, "idle");
  endtask

  // End of last visible line, then the snapshot line.
  task automatic frame_end(input logic [7:0] bg);
    px(639, 479, 1'b1, bg, -1, "eol479");
    exp_start_cyc = cyc + 1;
    px(640, 479, 1'b0, 8'h00, -1, "hblank479");
    px(641, 479, 1'b0, 8'h00, -1, "hblank479");
    px(0, 480, 1'b0, 8'h00, -1, "snap");
    px(1, 480, 1'b0, 8'h00, -1, "snap");
    idle(1);
    frames++;
  endtask

  // Monitor: all DUT outputs sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.RGB_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: RGB_VALID high with empty scoreboard, RGB=%0h", bus.RGB);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_rgb"}, 32'(bus.RGB), 32'(e.rgb));
          check({e.name, "_latency"}, 32'(cyc - e.issue), 32'd3);
        end
      end else begin
        check("rgb_zero_when_invalid", 32'(bus.RGB), 32'h0);
      end
      if (aq.size() > 0 && aq[0].issue + 1 <= cyc) begin
        addr_t a;
        a = aq.pop_front();
        check("block_addr", 32'(bus.BLOCK_ADDR), 32'(a.addr));
      end
      if (bus.START_UPDATE === 1'b1) begin
        n_start++;
        check("start_cycle", 32'(cyc), 32'(exp_start_cyc));
        check("start_width", 32'(start_prev), 32'd0);
      end
      start_prev = bus.START_UPDATE;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int saved_start;
    for (int i = 0; i < 72; i++) alive_mem[i] = 1'b1;
    alive_mem[72]      = 1'b0;
    bus.PIXEL_X        = '0;
    bus.PIXEL_Y        = '0;
    bus.PIXEL_VISIBLE  = 1'b0;
    bus.PADDLE_X_PIXEL = '0;
    bus.BALL_X_PIXEL   = '0;
    bus.BALL_Y_PIXEL   = '0;
    bus.BALL_LOST      = 1'b0;

    // Reset values.
    repeat (3) step();
    @(negedge clk);
    check("reset_rgb", 32'(bus.RGB), 32'h0);
    check("reset_valid", 32'(bus.RGB_VALID), 32'h0);
    check("reset_start", 32'(bus.START_UPDATE), 32'h0);
    check("reset_addr", 32'(bus.BLOCK_ADDR), 32'd72);
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 1: first block row, border vs interior, RGB_VALID gap.
    px(32, 64, 1'b1, 8'h00, 72 - 72, "t1_border");
    px(33, 65, 1'b1, 8'hE0, 0, "t1_blk0");
    px(34, 65, 1'b0, 8'h00, -1, "t1_invis");
    px(35, 65, 1'b1, 8'hE0, -1, "t1_blk0b");

    // 2: address sweep and a dead block.
    px(96, 80, 1'b1, 8'h00, 10, "t2_a10_border");
    px(607, 191, 1'b1, 8'h92, 71, "t2_a71");
    px(608, 100, 1'b1, 8'h00, 72, "t2_right_out");
    px(10, 10, 1'b1, 8'h00, 72, "t2_underflow");
    idle(3);
    alive_mem[10] = 1'b0;
    px(100, 84, 1'b1, 8'h00, 10, "t2_dead10");
    idle(3);
    alive_mem[10] = 1'b1;

    // 3: ball over a live block, paddle at 300.
    bus.BALL_X_PIXEL   = 10'd100;
    bus.BALL_Y_PIXEL   = 10'd84;
    bus.PADDLE_X_PIXEL = 10'd300;
    frame_end(8'h00);
    px(100, 84, 1'b1, 8'hFF, -1, "t3_ball_tl");
    px(107, 91, 1'b1, 8'hFF, -1, "t3_ball_br");
    px(108, 84, 1'b1, 8'hEC, -1, "t3_ball_right");
    px(100, 92, 1'b1, 8'hEC, -1, "t3_ball_below");
    px(299, 448, 1'b1, 8'h00, -1, "t3_pad_left");
    px(300, 448, 1'b1, 8'h1F, -1, "t3_pad_start");
    px(363, 455, 1'b1, 8'h1F, -1, "t3_pad_end");
    px(364, 455, 1'b1, 8'h00, -1, "t3_pad_right");
    px(300, 456, 1'b1, 8'h00, -1, "t3_pad_below");

    // 4: mid-frame input changes take effect only after the snapshot line.
    bus.BALL_X_PIXEL   = 10'd200;
    bus.BALL_Y_PIXEL   = 10'd200;
    bus.PADDLE_X_PIXEL = 10'd500;
    px(100, 84, 1'b1, 8'hFF, -1, "t4_old_ball");
    px(200, 200, 1'b1, 8'h00, -1, "t4_new_ball_early");
    px(300, 448, 1'b1, 8'h1F, -1, "t4_old_pad");
    frame_end(8'h00);
    px(200, 200, 1'b1, 8'hFF, -1, "t4_new_ball");
    px(100, 84, 1'b1, 8'hEC, -1, "t4_old_ball_gone");
    px(500, 450, 1'b1, 8'h1F, -1, "t4_new_pad");
    px(300, 448, 1'b1, 8'h00, -1, "t4_old_pad_gone");

    // 5: game over background, walls, ceiling, priorities.
    bus.BALL_LOST = 1'b1;
    px(10, 10, 1'b1, 8'h60, -1, "t5_bg_lost");
    px(20, 200, 1'b1, 8'h92, -1, "t5_wall_l");
    px(15, 200, 1'b1, 8'h60, -1, "t5_left_of_wall");
    px(620, 300, 1'b1, 8'h92, -1, "t5_wall_r");
    px(624, 300, 1'b1, 8'h60, -1, "t5_right_of_wall");
    px(320, 50, 1'b1, 8'h92, -1, "t5_ceiling");
    px(200, 200, 1'b1, 8'hFF, -1, "t5_ball");
    px(33, 65, 1'b1, 8'hE0, -1, "t5_block");
    frame_end(8'h60);
    bus.BALL_LOST = 1'b0;
    idle(3);

    // 6: reset in the middle of the end of line 479.
    px(50, 100, 1'b1, 8'hFC, -1, "t6_flushed_a");
    px(639, 479, 1'b1, 8'h00, -1, "t6_flushed_b");
    saved_start       = n_start;
    bus.PIXEL_X       = 10'd640;
    bus.PIXEL_VISIBLE = 1'b0;
    rst               = 1'b1;
    step();
    sb.delete();
    aq.delete();
    @(negedge clk);
    check("t6_rst_rgb", 32'(bus.RGB), 32'h0);
    check("t6_rst_valid", 32'(bus.RGB_VALID), 32'h0);
    check("t6_rst_start", 32'(bus.START_UPDATE), 32'h0);
    check("t6_rst_addr", 32'(bus.BLOCK_ADDR), 32'd72);
    step();
    rst = 1'b0;
    px(641, 479, 1'b0, 8'h00, -1, "t6_after_rst");
    px(3, 3, 1'b1, 8'hFF, -1, "t6_snap_zero_ball");
    px(10, 450, 1'b1, 8'h1F, -1, "t6_snap_zero_pad");
    px(200, 200, 1'b1, 8'h00, -1, "t6_no_snap_yet");
    px(33, 65, 1'b1, 8'hE0, -1, "t6_block");
    idle(5);
    check("t6_no_start_around_reset", 32'(n_start), 32'(saved_start));

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("start_per_frame", 32'(n_start), 32'(frames));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
